sid_bus_slave: RTL and testbench

SID_BUS_SLAVE -- requirements
Module: sid_bus_slave

---
 rtl/sid_bus_slave.sv | 153 +++++++++++++++
 tb/tb_sid_bus_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_slave.sv
// sid_bus_slave
//   Register front end for a three-voice SID-style synthesiser. A host with
//   no clock relationship to clk writes bytes over a strobe/address/voice/
//   data bus. The bus is resynchronised, one write is accepted per strobe
//   pulse, and the write updates the addressed per-voice register field.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_strobe    host write strobe (asynchronous to clk)
//   addr[2:0]    register address: 0/1 freq lo/hi, 2/3 pw lo/hi, 4 ad, 5 sr,
//                6 wav, 7 reserved
//   voice[1:0]   voice select, 0..2 valid
//   data_in[7:0] write data
//   freq_o[47:0] 16-bit frequency word per voice, voice v at [16v+15:16v]
//   pw_o[35:0]   12-bit pulse width per voice, voice v at [12v+11:12v]
//   ad_o, sr_o, wav_o [23:0]  byte per voice, voice v at [8v+7:8v]
//   gate_rise_o, gate_fall_o [2:0]  one-cycle pulse when a wav write sets or
//                clears bit0 of that voice's wav byte
//   wr_ack_o     one-cycle pulse for an accepted write
//   wr_err_o     one-cycle pulse for a rejected write (voice 3 or addr 7)
//
// SYNC_STAGES sets the synchroniser depth (2 or 3). Write latency is
// SYNC_STAGES+1 edges from the first edge that samples the strobe high.
module sid_bus_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_strobe,
    input  logic [2:0]  addr,
    input  logic [1:0]  voice,
    input  logic [7:0]  data_in,
    output logic [47:0] freq_o,
    output logic [35:0] pw_o,
    output logic [23:0] ad_o,
    output logic [23:0] sr_o,
    output logic [23:0] wav_o,
    output logic [2:0]  gate_rise_o,
    output logic [2:0]  gate_fall_o,
    output logic        wr_ack_o,
    output logic        wr_err_o
);

    localparam int BUS_W = 14;  // {strobe, voice[1:0], addr[2:0], data[7:0]}

    // All bus bits go through the same chain so the strobe edge and the
    // address/data it qualifies leave the synchroniser on the same cycle.
    logic [BUS_W-1:0] sync_reg [SYNC_STAGES];
    logic [BUS_W-1:0] bus_in;

    assign bus_in = {wr_strobe, voice, addr, data_in};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= bus_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic       s_strobe;
    logic [1:0] s_voice;
    logic [2:0] s_addr;
    logic [7:0] s_data;

    assign {s_strobe, s_voice, s_addr, s_data} = sync_reg[SYNC_STAGES-1];

    // Rising-edge detect on the synchronised strobe: a long pulse still
    // yields a single write event.
    logic strobe_dly_reg;
    logic wr_event;
    logic wr_valid;

    assign wr_event = s_strobe & ~strobe_dly_reg;
    assign wr_valid = (s_voice != 2'd3) && (s_addr != 3'd7);

    logic [15:0] freq_reg [3];
    logic [11:0] pw_reg   [3];
    logic [7:0]  ad_reg   [3];
    logic [7:0]  sr_reg   [3];
    logic [7:0]  wav_reg  [3];

    logic [2:0] rise_next;
    logic [2:0] fall_next;

    // Gate edges compare the incoming wav bit0 with the value it replaces.
    always_comb begin
        rise_next = '0;
        fall_next = '0;
        for (int v = 0; v < 3; v++) begin
            if (wr_event && wr_valid && s_addr == 3'd6 && s_voice == 2'(v)) begin
                rise_next[v] = s_data[0] & ~wav_reg[v][0];
                fall_next[v] = ~s_data[0] & wav_reg[v][0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_dly_reg <= 1'b0;
            wr_ack_o       <= 1'b0;
            wr_err_o       <= 1'b0;
            gate_rise_o    <= '0;
            gate_fall_o    <= '0;
            for (int v = 0; v < 3; v++) begin
                freq_reg[v] <= '0;
                pw_reg[v]   <= '0;
                ad_reg[v]   <= '0;
                sr_reg[v]   <= '0;
                wav_reg[v]  <= '0;
            end
        end else begin
            strobe_dly_reg <= s_strobe;
            wr_ack_o       <= wr_event & wr_valid;
            wr_err_o       <= wr_event & ~wr_valid;
            gate_rise_o    <= rise_next;
            gate_fall_o    <= fall_next;
            for (int v = 0; v < 3; v++) begin
                if (wr_event && wr_valid && s_voice == 2'(v)) begin
                    case (s_addr)
                        3'd0: freq_reg[v][7:0]  <= s_data;
                        3'd1: freq_reg[v][15:8] <= s_data;
                        3'd2: pw_reg[v][7:0]    <= s_data;
                        3'd3: pw_reg[v][11:8]   <= s_data[3:0];
                        3'd4: ad_reg[v]         <= s_data;
                        3'd5: sr_reg[v]         <= s_data;
                        3'd6: wav_reg[v]        <= s_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Outputs are plain wiring of the field registers into the flat buses.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_out
            assign freq_o[16*gi +: 16] = freq_reg[gi];
            assign pw_o[12*gi +: 12]   = pw_reg[gi];
            assign ad_o[8*gi +: 8]     = ad_reg[gi];
            assign sr_o[8*gi +: 8]     = sr_reg[gi];
            assign wav_o[8*gi +: 8]    = wav_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sid_bus_slave.sv
// Self-checking bench for sid_bus_slave: directed cases for latency, gate
// edges, rejected writes, back-to-back and merged strobes and reset
// behaviour, followed by randomized writes checked against a field-level
// model of the register file.
module tb_sid_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_strobe = 1'b0;
    logic [2:0]  addr = '0;
    logic [1:0]  voice = '0;
    logic [7:0]  data_in = '0;
    logic [47:0] freq_o;
    logic [35:0] pw_o;
    logic [23:0] ad_o, sr_o, wav_o;
    logic [2:0]  gate_rise_o, gate_fall_o;
    logic        wr_ack_o, wr_err_o;

    sid_bus_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .addr(addr),
        .voice(voice), .data_in(data_in), .freq_o(freq_o), .pw_o(pw_o),
        .ad_o(ad_o), .sr_o(sr_o), .wav_o(wav_o), .gate_rise_o(gate_rise_o),
        .gate_fall_o(gate_fall_o), .wr_ack_o(wr_ack_o), .wr_err_o(wr_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: field values per voice and expected pulse totals.
    logic [15:0] m_freq [3];
    logic [11:0] m_pw   [3];
    logic [7:0]  m_ad   [3];
    logic [7:0]  m_sr   [3];
    logic [7:0]  m_wav  [3];
    int exp_ack = 0, exp_err = 0;
    int exp_rise [3] = '{0, 0, 0};
    int exp_fall [3] = '{0, 0, 0};

    // Observed pulse totals, sampled mid-cycle.
    int ack_cycles = 0, err_cycles = 0, stray_gate = 0;
    int rise_cnt [3] = '{0, 0, 0};
    int fall_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (wr_ack_o) ack_cycles++;
        if (wr_err_o) err_cycles++;
        for (int v = 0; v < 3; v++) begin
            if (gate_rise_o[v]) rise_cnt[v]++;
            if (gate_fall_o[v]) fall_cnt[v]++;
        end
        if ((gate_rise_o != 3'b000 || gate_fall_o != 3'b000) && !wr_ack_o) stray_gate++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 3; v++) begin
            m_freq[v] = '0; m_pw[v] = '0; m_ad[v] = '0; m_sr[v] = '0; m_wav[v] = '0;
        end
    endtask

    task automatic model_write(input int v, input int a, input logic [7:0] d);
        if (v == 3 || a == 7) begin
            exp_err++;
        end else begin
            exp_ack++;
            case (a)
                0: m_freq[v][7:0]  = d;
                1: m_freq[v][15:8] = d;
                2: m_pw[v][7:0]    = d;
                3: m_pw[v][11:8]   = d[3:0];
                4: m_ad[v]         = d;
                5: m_sr[v]         = d;
                default: begin
                    if (!m_wav[v][0] && d[0]) exp_rise[v]++;
                    if (m_wav[v][0] && !d[0]) exp_fall[v]++;
                    m_wav[v] = d;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [47:0] ef;
        logic [35:0] ep;
        logic [23:0] ea, es, ew;
        for (int v = 0; v < 3; v++) begin
            ef[16*v +: 16] = m_freq[v];
            ep[12*v +: 12] = m_pw[v];
            ea[8*v +: 8]   = m_ad[v];
            es[8*v +: 8]   = m_sr[v];
            ew[8*v +: 8]   = m_wav[v];
        end
        check({tag, ".freq"}, 64'(freq_o), 64'(ef));
        check({tag, ".pw"},   64'(pw_o),   64'(ep));
        check({tag, ".ad"},   64'(ad_o),   64'(ea));
        check({tag, ".sr"},   64'(sr_o),   64'(es));
        check({tag, ".wav"},  64'(wav_o),  64'(ew));
        check({tag, ".acks"}, 64'(ack_cycles), 64'(exp_ack));
        check({tag, ".errs"}, 64'(err_cycles), 64'(exp_err));
        check({tag, ".rise"}, {rise_cnt[2][15:0], rise_cnt[1][15:0], rise_cnt[0][15:0]},
                              {exp_rise[2][15:0], exp_rise[1][15:0], exp_rise[0][15:0]});
        check({tag, ".fall"}, {fall_cnt[2][15:0], fall_cnt[1][15:0], fall_cnt[0][15:0]},
                              {exp_fall[2][15:0], exp_fall[1][15:0], exp_fall[0][15:0]});
        check({tag, ".stray_gate"}, 64'(stray_gate), 64'd0);
        $display("%0t %s: freq=%h pw=%h ad=%h sr=%h wav=%h acks=%0d errs=%0d",
                 $time, tag, freq_o, pw_o, ad_o, sr_o, wav_o, ack_cycles, err_cycles);
    endtask

    // Host write: strobe high for hi cycles, low for lo cycles, bus held
    // stable for the whole transaction.
    task automatic host_write(input int v, input int a, input logic [7:0] d,
                              input int hi, input int lo);
        @(posedge clk); #1;
        voice = 2'(v); addr = 3'(a); data_in = d; wr_strobe = 1'b1;
        repeat (hi) @(posedge clk);
        #1 wr_strobe = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        model_write(v, a, d);
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Latency: value must appear after the third edge, not the second.
        @(posedge clk); #1;
        voice = 2'd0; addr = 3'd0; data_in = 8'd17; wr_strobe = 1'b1;
        @(posedge clk); #1 wr_strobe = 1'b0;   // edge 1 sampled the strobe
        @(posedge clk);                          // edge 2
        @(negedge clk);
        check("lat_edge2.freq", 64'(freq_o), 64'd0);
        check("lat_edge2.ack", 64'(wr_ack_o), 64'd0);
        @(posedge clk);                          // edge 3
        @(negedge clk);
        check("lat_edge3.freq", 64'(freq_o), 64'h11);
        check("lat_edge3.ack", 64'(wr_ack_o), 64'd1);
        repeat (3) @(posedge clk); #1;
        model_write(0, 0, 8'd17);
        check_all("wr_freq_lo_v0");

        host_write(2, 3, 8'hAB, 2, 3);
        check_all("wr_pw_hi_v2");

        host_write(1, 6, 8'h11, 1, 3);
        check_all("wav_rise_v1");
        host_write(1, 6, 8'h10, 3, 3);
        check_all("wav_fall_v1");
        host_write(1, 6, 8'h30, 1, 3);
        check_all("wav_nochange_v1");

        host_write(3, 0, 8'h55, 1, 3);
        host_write(0, 7, 8'h66, 2, 3);
        check_all("rejected");

        // Back-to-back with the 3-cycle host pattern.
        host_write(0, 0, 8'h5A, 1, 2);
        host_write(0, 4, 8'h00, 1, 2);
        host_write(0, 5, 8'h0F, 1, 2);
        host_write(0, 6, 8'h11, 1, 2);
        repeat (3) @(posedge clk); #1;
        check_all("back_to_back");

        // Strobe glitching low between edges: one merged write.
        @(posedge clk); #1;
        voice = 2'd2; addr = 3'd4; data_in = 8'hC3; wr_strobe = 1'b1;
        @(posedge clk); #1;
        #2 wr_strobe = 1'b0;
        #2 wr_strobe = 1'b1;
        @(posedge clk); #1 wr_strobe = 1'b0;
        repeat (4) @(posedge clk); #1;
        model_write(2, 4, 8'hC3);
        check_all("merged_strobe");

        // Randomized writes.
        for (int i = 0; i < 60; i++) begin
            host_write($urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom_range(0, 255)),
                       $urandom_range(1, 4), $urandom_range(3, 5));
            check_all($sformatf("rand%0d", i));
        end

        // Reset one cycle after the strobe aborts the write.
        @(posedge clk); #1;
        voice = 2'd1; addr = 3'd6; data_in = 8'hFF; wr_strobe = 1'b1;
        @(posedge clk); #1 wr_strobe = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("in_reset");
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        check_all("abort_after_reset");

        // Strobe held high across reset release: exactly one write.
        voice = 2'd2; addr = 3'd5; data_in = 8'h77; wr_strobe = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk); #1 wr_strobe = 1'b0;
        repeat (4) @(posedge clk); #1;
        model_write(2, 5, 8'h77);
        check_all("strobe_across_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
